sd_spi_card_responder: RTL

//  SPI-mode SD card responder (SPI mode 0): the card side of the SD SPI link our host controller drives.

---
 rtl/sd_spi_card_responder.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: card side of an SD card link in SPI mode 0.
// Decodes CMD0/CMD55/ACMD41/CMD58/CMD17, answers with R1/R3, and streams one
// 512-byte block from an external byte memory for CMD17.
// Optional feature macro SD_RESP_CRC16_EN: when defined, the two bytes after the
// data block carry CRC16-CCITT (poly 0x1021, init 0) of the block; otherwise 0xFF,0xFF.
//
// SPI byte interface: a byte is complete on the 8th synchronized SCK rising edge
// while CS is low; that same cycle the response byte for the next slot is loaded
// and its MSB appears on MISO. Later bits change on SCK falling edges.
module sd_spi_card_responder #(
    parameter int BLK_W      = 16,
    parameter int INIT_POLLS = 3,
    parameter int ACCESS_GAP = 4
) (
    input  logic             MasterCLK,
    input  logic             Reset,
    input  logic             SPI_CLK,
    input  logic             SPI_MOSI,
    input  logic             SPI_CS,
    output logic             SPI_MISO,
    output logic [BLK_W+8:0] MemAddr,
    output logic             MemRead,
    input  logic [7:0]       MemData,
    output logic             CardReady,
    output logic             CmdStrobe,
    output logic [5:0]       CmdIndex
);

    localparam int PW = (INIT_POLLS > 0) ? $clog2(INIT_POLLS + 1) : 1;

    typedef enum logic [2:0] {
        S_CMD, S_NCR, S_R1, S_OCR, S_GAP, S_TOKEN, S_DATA, S_CRC
    } state_t;

    // synchronizers and SPI bit layer
    logic       sck_s1_q, sck_s2_q, sck_prev_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic       cs_s1_q, cs_s2_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [6:0] tx_q;
    logic       miso_q;
    logic       cs_act, sck_rise, sck_fall, byte_done;
    logic [7:0] rx_byte;

    // parser
    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] tx_next;
    logic       accept, cmd_byte0, arg_shift, rd_issue;
    logic [8:0] rd_idx;

    // card / command state
    logic [5:0]       cur_idx_q;
    logic [BLK_W-1:0] blk_q;
    logic [7:0]       r1_q;
    logic             go17_q;
    logic             app_q;
    logic [PW-1:0]    polls_q;
    logic             card_ready_q;
    logic             strobe_q;
    logic [5:0]       cmd_idx_q;

    // memory prefetch
    logic             mem_read_q;
    logic             cap_q;
    logic [BLK_W+8:0] mem_addr_q;
    logic [7:0]       pf_q;

    assign cs_act    = ~cs_s2_q;
    assign sck_rise  = sck_s2_q & ~sck_prev_q;
    assign sck_fall  = ~sck_s2_q & sck_prev_q;
    assign byte_done = cs_act & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q, mosi_s2_q};

`ifdef SD_RESP_CRC16_EN
    logic [15:0] crc_q;
    logic        data_load, token_enter;

    assign data_load   = byte_done && (state_d == S_DATA);
    assign token_enter = byte_done && (state_d == S_TOKEN);

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // CRC accumulates each data byte as it is loaded into the tx shifter
    always_ff @(posedge MasterCLK) begin
        if (!Reset)           crc_q <= '0;
        else if (token_enter) crc_q <= '0;
        else if (data_load)   crc_q <= crc16_step(crc_q, pf_q);
    end
`endif

    // two-flop synchronizers plus SCK history for edge detection
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
        end else begin
            sck_s1_q   <= SPI_CLK;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            mosi_s1_q  <= SPI_MOSI;
            mosi_s2_q  <= mosi_s1_q;
            cs_s1_q    <= SPI_CS;
            cs_s2_q    <= cs_s1_q;
        end
    end

    // bit layer: shift in on rise, load next byte at byte end, shift out on fall
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= 7'h7F;
            miso_q    <= 1'b1;
        end else if (!cs_act) begin
            bit_cnt_q <= '0;
            tx_q      <= 7'h7F;
            miso_q    <= 1'b1;
        end else if (sck_rise) begin
            rx_q      <= {rx_q[5:0], mosi_s2_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                tx_q   <= tx_next[6:0];
                miso_q <= tx_next[7];
            end
        // the fall right after a load belongs to the new byte's MSB: no shift
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_q   <= {tx_q[5:0], 1'b1};
            miso_q <= tx_q[6];
        end
    end

    // parser state register: advances once per byte, forced to S_CMD while deselected
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            state_q <= S_CMD;
            cnt_q   <= '0;
        end else if (!cs_act) begin
            state_q <= S_CMD;
            cnt_q   <= '0;
        end else if (byte_done) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // parser next state and per-state byte counter (meaningful only on byte_done)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 10'd1;
        case (state_q)
            S_CMD: begin
                if (cnt_q == 10'd0 && rx_byte[7:6] != 2'b01) cnt_d = cnt_q;
                else if (cnt_q == 10'd5)                     state_d = S_NCR;
            end
            S_NCR:   state_d = S_R1;
            S_R1: begin
                if (cur_idx_q == 6'd58) state_d = S_OCR;
                else if (go17_q)        state_d = S_GAP;
                else                    state_d = S_CMD;
            end
            S_OCR:   if (cnt_q == 10'd3) state_d = S_CMD;
            S_GAP:   if (cnt_q == 10'(ACCESS_GAP - 1)) state_d = S_TOKEN;
            S_TOKEN: state_d = S_DATA;
            S_DATA:  if (cnt_q == 10'd511) state_d = S_CRC;
            S_CRC:   if (cnt_q == 10'd1) state_d = S_CMD;
            default: state_d = S_CMD;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // parser outputs: byte to load for the next slot and per-byte strobes
    always_comb begin
        tx_next   = 8'hFF;
        accept    = byte_done && (state_q == S_CMD) && (state_d == S_NCR);
        cmd_byte0 = byte_done && (state_q == S_CMD) && (cnt_q == 10'd0) && (rx_byte[7:6] == 2'b01);
        arg_shift = byte_done && (state_q == S_CMD) && (cnt_q >= 10'd1) && (cnt_q <= 10'd4);
        rd_issue  = byte_done && ((state_d == S_TOKEN) ||
                                  ((state_d == S_DATA) && (cnt_d != 10'd511)));
        rd_idx    = (state_d == S_TOKEN) ? 9'd0 : (cnt_d[8:0] + 9'd1);
        case (state_d)
            S_R1:    tx_next = r1_q;
            S_OCR: begin
                case (cnt_d[1:0])
                    2'd0:    tx_next = card_ready_q ? 8'hC0 : 8'h00;
                    2'd1:    tx_next = 8'hFF;
                    2'd2:    tx_next = 8'h80;
                    default: tx_next = 8'h00;
                endcase
            end
            S_TOKEN: tx_next = 8'hFE;
            S_DATA:  tx_next = pf_q;
`ifdef SD_RESP_CRC16_EN
            S_CRC:   tx_next = (cnt_d == 10'd0) ? crc_q[15:8] : crc_q[7:0];
`endif
            default: tx_next = 8'hFF;
        endcase
    end

    // command capture, R1 evaluation and card init state (survives CS aborts)
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            cur_idx_q    <= '0;
            blk_q        <= '0;
            r1_q         <= 8'hFF;
            go17_q       <= 1'b0;
            app_q        <= 1'b0;
            polls_q      <= PW'(INIT_POLLS);
            card_ready_q <= 1'b0;
            strobe_q     <= 1'b0;
            cmd_idx_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (cmd_byte0) cur_idx_q <= rx_byte[5:0];
            if (arg_shift) blk_q <= BLK_W'({blk_q, rx_byte});
            if (accept) begin
                strobe_q  <= 1'b1;
                cmd_idx_q <= cur_idx_q;
                go17_q    <= 1'b0;
                app_q     <= 1'b0;
                case (cur_idx_q)
                    6'd0: begin
                        r1_q         <= 8'h01;
                        card_ready_q <= 1'b0;
                        polls_q      <= PW'(INIT_POLLS);
                    end
                    6'd55: begin
                        r1_q  <= {7'b0, ~card_ready_q};
                        app_q <= 1'b1;
                    end
                    6'd41: begin
                        if (!app_q) begin
                            r1_q <= {5'b0, 1'b1, 1'b0, ~card_ready_q};
                        end else if (polls_q != '0) begin
                            r1_q    <= 8'h01;
                            polls_q <= polls_q - PW'(1);
                        end else begin
                            r1_q         <= 8'h00;
                            card_ready_q <= 1'b1;
                        end
                    end
                    6'd58: r1_q <= {7'b0, ~card_ready_q};
                    6'd17: begin
                        r1_q   <= card_ready_q ? 8'h00 : 8'h05;
                        go17_q <= card_ready_q;
                    end
                    default: r1_q <= {5'b0, 1'b1, 1'b0, ~card_ready_q};
                endcase
            end
        end
    end

    // block prefetch: read strobe right after each token/data load, capture one cycle later
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            mem_read_q <= 1'b0;
            cap_q      <= 1'b0;
            mem_addr_q <= '0;
            pf_q       <= '0;
        end else if (!cs_act) begin
            mem_read_q <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            mem_read_q <= rd_issue;
            cap_q      <= mem_read_q;
            if (rd_issue) mem_addr_q <= {blk_q, rd_idx};
            if (cap_q)    pf_q <= MemData;
        end
    end

    assign SPI_MISO  = miso_q;
    assign MemAddr   = mem_addr_q;
    assign MemRead   = mem_read_q;
    assign CardReady = card_ready_q;
    assign CmdStrobe = strobe_q;
    assign CmdIndex  = cmd_idx_q;

endmodule
